id_ex_forward_stage: RTL

//   ID/EX pipeline register plus operand-forwarding and load-use hazard logic.

---
 rtl/id_ex_forward_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding (EX/MEM, MEM/WB)
// and load-use hazard detection that stalls ID and injects a bubble.
module id_ex_forward_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic                     id_uses_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_operation,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     flush,
    input  logic [REG_ADDR-1:0]      exmem_rd,
    input  logic                     exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [REG_ADDR-1:0]      memwb_rd,
    input  logic                     memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     stall_id,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic [CNT_WIDTH-1:0]     bubble_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                     ex_valid_reg;
    logic [REG_ADDR-1:0]      ex_rs_reg      [2];
    logic [DATA_WIDTH-1:0]    ex_rs_data_reg [2];
    logic [REG_ADDR-1:0]      ex_rd_reg;
    logic [DATA_WIDTH-1:0]    ex_imm_reg;
    logic                     ex_alu_src_reg;
    logic [OPCODE_LENGTH-1:0] ex_operation_reg;
    logic                     ex_reg_write_reg;
    logic                     ex_mem_read_reg;
    logic [CNT_WIDTH-1:0]     bubble_count_reg;
    logic [CNT_WIDTH-1:0]     bubble_count_next;

    logic load_use;
    logic insert_bubble;

    // A load in EX cannot supply its data to the very next instruction.
    always_comb begin
        load_use = ex_valid_reg && ex_mem_read_reg && (ex_rd_reg != '0) && id_valid &&
                   ((ex_rd_reg == id_rs1) || (id_uses_rs2 && (ex_rd_reg == id_rs2)));
    end

    assign stall_id      = load_use;
    assign insert_bubble = flush || load_use;

    // Flushed cycles are not load-use bubbles, so they are not counted.
    always_comb begin
        bubble_count_next = bubble_count_reg;
        if (!flush && load_use && (bubble_count_reg != {CNT_WIDTH{1'b1}})) begin
            bubble_count_next = bubble_count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_reg      <= 1'b0;
            ex_rs_reg[0]      <= '0;
            ex_rs_reg[1]      <= '0;
            ex_rs_data_reg[0] <= '0;
            ex_rs_data_reg[1] <= '0;
            ex_rd_reg         <= '0;
            ex_imm_reg        <= '0;
            ex_alu_src_reg    <= 1'b0;
            ex_operation_reg  <= '0;
            ex_reg_write_reg  <= 1'b0;
            ex_mem_read_reg   <= 1'b0;
            bubble_count_reg  <= '0;
        end else begin
            bubble_count_reg <= bubble_count_next;
            if (insert_bubble) begin
                // Operand fields keep stale data; only control is killed.
                ex_valid_reg     <= 1'b0;
                ex_rd_reg        <= '0;
                ex_alu_src_reg   <= 1'b0;
                ex_operation_reg <= '0;
                ex_reg_write_reg <= 1'b0;
                ex_mem_read_reg  <= 1'b0;
            end else begin
                ex_valid_reg      <= id_valid;
                ex_rs_reg[0]      <= id_rs1;
                ex_rs_reg[1]      <= id_rs2;
                ex_rs_data_reg[0] <= id_rs1_data;
                ex_rs_data_reg[1] <= id_rs2_data;
                ex_rd_reg         <= id_rd;
                ex_imm_reg        <= id_imm;
                ex_alu_src_reg    <= id_valid && id_alu_src;
                ex_operation_reg  <= id_valid ? id_operation : '0;
                ex_reg_write_reg  <= id_valid && id_reg_write;
                ex_mem_read_reg   <= id_valid && id_mem_read;
            end
        end
    end

    // Per-operand forwarding mux; EX/MEM is newer than MEM/WB so it wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [DATA_WIDTH-1:0] fwd;
            always_comb begin
                fwd = ex_rs_data_reg[gi];
                if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs_reg[gi])) begin
                    fwd = exmem_result;
                end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs_reg[gi])) begin
                    fwd = memwb_result;
                end
            end
        end
    endgenerate

    assign SrcA          = g_fwd[0].fwd;
    assign SrcB          = ex_alu_src_reg ? ex_imm_reg : g_fwd[1].fwd;
    assign ex_store_data = g_fwd[1].fwd;
    assign Operation     = ex_operation_reg;
    assign ex_valid      = ex_valid_reg;
    assign ex_rd         = ex_rd_reg;
    assign ex_reg_write  = ex_reg_write_reg;
    assign ex_mem_read   = ex_mem_read_reg;
    assign bubble_count  = bubble_count_reg;

endmodule
